// File: rtl/spine_link_adapter.sv
// rtl/spine_link_adapter.sv - leaf-router spine port to valid/ready spine link adapter
// TX: FWFT FIFO with drop accounting; RX: paced single-cycle replay with dest extraction.
module spine_link_adapter #(
    parameter int DWIDTH     = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_LSB   = 10,
    parameter int RX_GAP     = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DWIDTH-1:0]             leaf_out_data,
    input  logic                          leaf_out_valid,
    output logic [DWIDTH-1:0]             leaf_in_data,
    output logic                          leaf_in_valid,
    output logic [5:0]                    leaf_dest_addr,
    output logic [DWIDTH-1:0]             spine_tx_data,
    output logic                          spine_tx_valid,
    input  logic                          spine_tx_ready,
    input  logic [DWIDTH-1:0]             spine_rx_data,
    input  logic                          spine_rx_valid,
    output logic                          spine_rx_ready,
    input  logic                          clr_stats,
    output logic                          tx_overflow,
    output logic [7:0]                    drop_count,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [DWIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [LW-1:0]     level;
    logic              full, push, pop, drop;

    assign full = (level == LW'(FIFO_DEPTH));
    assign pop  = (level != '0) && spine_tx_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push = leaf_out_valid && (!full || pop);
    assign drop = leaf_out_valid && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= leaf_out_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    assign spine_tx_valid = (level != '0);
    assign spine_tx_data  = spine_tx_valid ? mem[rd_ptr] : '0;
    assign tx_level       = level;

    // A drop in the clearing cycle is still counted, so the clear never hides it.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_overflow <= 1'b0;
            drop_count  <= 8'd0;
        end else if (clr_stats) begin
            tx_overflow <= drop;
            drop_count  <= {7'd0, drop};
        end else if (drop) begin
            tx_overflow <= 1'b1;
            if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } rx_state_t;

    rx_state_t         state, next_state;
    logic [DWIDTH-1:0] rx_data;
    logic [3:0]        gap_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rx_data <= '0;
            gap_cnt <= 4'd0;
        end else begin
            state <= next_state;
            if (state == IDLE && spine_rx_valid) begin
                rx_data <= spine_rx_data;
            end
            if (state == SEND) begin
                gap_cnt <= 4'(RX_GAP);
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        next_state     = state;
        leaf_in_valid  = 1'b0;
        spine_rx_ready = 1'b0;
        case (state)
            IDLE: begin
                spine_rx_ready = 1'b1;
                if (spine_rx_valid) begin
                    next_state = SEND;
                end
            end
            SEND: begin
                leaf_in_valid = 1'b1;
                next_state    = (RX_GAP > 0) ? GAP : IDLE;
            end
            GAP: begin
                if (gap_cnt <= 4'd1) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign leaf_in_data   = rx_data;
    assign leaf_dest_addr = rx_data[ADDR_LSB+5:ADDR_LSB];

endmodule

// File: tb/tb_spine_link_adapter.sv
// tb/tb_spine_link_adapter.sv - self-checking bench for spine_link_adapter
// Queue-based TX model and time-slot RX model checked every cycle, plus vector table and directed cases.
module tb_spine_link_adapter;
    localparam int DEPTH  = 8;
    localparam int RX_GAP = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] leaf_out_data;
    logic        leaf_out_valid;
    logic [15:0] leaf_in_data;
    logic        leaf_in_valid;
    logic [5:0]  leaf_dest_addr;
    logic [15:0] spine_tx_data;
    logic        spine_tx_valid;
    logic        spine_tx_ready;
    logic [15:0] spine_rx_data;
    logic        spine_rx_valid;
    logic        spine_rx_ready;
    logic        clr_stats;
    logic        tx_overflow;
    logic [7:0]  drop_count;
    logic [3:0]  tx_level;

    spine_link_adapter #(
        .DWIDTH(16), .FIFO_DEPTH(DEPTH), .ADDR_LSB(10), .RX_GAP(RX_GAP)
    ) dut (
        .clk(clk), .reset(reset),
        .leaf_out_data(leaf_out_data), .leaf_out_valid(leaf_out_valid),
        .leaf_in_data(leaf_in_data), .leaf_in_valid(leaf_in_valid),
        .leaf_dest_addr(leaf_dest_addr),
        .spine_tx_data(spine_tx_data), .spine_tx_valid(spine_tx_valid),
        .spine_tx_ready(spine_tx_ready),
        .spine_rx_data(spine_rx_data), .spine_rx_valid(spine_rx_valid),
        .spine_rx_ready(spine_rx_ready),
        .clr_stats(clr_stats), .tx_overflow(tx_overflow),
        .drop_count(drop_count), .tx_level(tx_level)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          t        = 0;
    int          rx_free_at = 0;
    int          deliver_at = -1;
    logic [15:0] last_rx  = 16'h0;
    logic [15:0] mq[$];
    logic        m_ovf    = 1'b0;
    int          m_cnt    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, t);
        end
    endtask

    // Apply one cycle of inputs, advance the model across the edge, then compare.
    task automatic drive_cycle(input logic rst, input logic lv, input logic [15:0] ld,
                               input logic tr, input logic rv, input logic [15:0] rd,
                               input logic clr);
        logic was_full, popped, dropped;
        reset = rst; leaf_out_valid = lv; leaf_out_data = ld; spine_tx_ready = tr;
        spine_rx_valid = rv; spine_rx_data = rd; clr_stats = clr;
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0; m_cnt = 0;
            rx_free_at = t + 1; deliver_at = -1; last_rx = 16'h0;
        end else begin
            was_full = (mq.size() == DEPTH);
            popped   = (mq.size() != 0) && tr;
            dropped  = lv && was_full && !popped;
            if (popped) void'(mq.pop_front());
            if (lv && !dropped) mq.push_back(ld);
            if (clr) begin
                m_ovf = dropped; m_cnt = dropped ? 1 : 0;
            end else if (dropped) begin
                m_ovf = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
            if (t >= rx_free_at && rv) begin
                deliver_at = t + 1;
                rx_free_at = t + 2 + RX_GAP;
                last_rx    = rd;
            end
        end
        @(posedge clk);
        #1;
        t++;
        chk("tx_valid", spine_tx_valid, mq.size() != 0);
        chk("tx_data", spine_tx_data, (mq.size() != 0) ? mq[0] : 16'h0);
        chk("tx_level", tx_level, mq.size());
        chk("tx_overflow", tx_overflow, m_ovf);
        chk("drop_count", drop_count, m_cnt);
        chk("leaf_in_valid", leaf_in_valid, t == deliver_at);
        chk("leaf_in_data", leaf_in_data, last_rx);
        chk("leaf_dest_addr", leaf_dest_addr, last_rx[15:10]);
        chk("rx_ready", spine_rx_ready, t >= rx_free_at);
    endtask

    typedef struct {
        logic        rst;
        logic        lv;
        logic [15:0] ld;
        logic        tr;
        logic        rv;
        logic [15:0] rd;
        logic        clr;
        int          exp_level;
        int          exp_drops;
        logic        exp_liv;
        logic [5:0]  exp_dest;
    } vec_t;

    vec_t vt[13];

    initial begin
        vt[0] = '{1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 0, 0, 1'b0, 6'h00};
        for (int i = 1; i <= 7; i++)
            vt[i] = '{1'b0, 1'b1, 16'h0400 + 16'(i), 1'b0, 1'b1, 16'hA8F0, 1'b0,
                      i, 0, (i % 3 == 1), 6'h2A};
        vt[8]  = '{1'b0, 1'b1, 16'h0408, 1'b0, 1'b0, 16'h0, 1'b0, 8, 0, 1'b0, 6'h2A};
        vt[9]  = '{1'b0, 1'b1, 16'h0409, 1'b0, 1'b0, 16'h0, 1'b0, 8, 1, 1'b0, 6'h2A};
        vt[10] = '{1'b0, 1'b1, 16'h040A, 1'b1, 1'b0, 16'h0, 1'b0, 8, 1, 1'b0, 6'h2A};
        vt[11] = '{1'b0, 1'b1, 16'h040B, 1'b0, 1'b0, 16'h0, 1'b1, 8, 1, 1'b0, 6'h2A};
        vt[12] = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 8, 0, 1'b0, 6'h2A};

        // Vector table: RX pacing of a held flit alongside TX fill, full push+pop, clear+drop
        for (int i = 0; i < 13; i++) begin
            drive_cycle(vt[i].rst, vt[i].lv, vt[i].ld, vt[i].tr, vt[i].rv, vt[i].rd, vt[i].clr);
            chk("vec_level", tx_level, vt[i].exp_level);
            chk("vec_drops", drop_count, vt[i].exp_drops);
            chk("vec_liv", leaf_in_valid, vt[i].exp_liv);
            chk("vec_dest", leaf_dest_addr, vt[i].exp_dest);
        end

        // Back-to-back flits with spine ready: each appears one cycle after its push
        drive_cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b0, 1'b1, 16'h0401 + 16'(i), 1'b1, 1'b0, 16'h0, 1'b0);
            chk("t1_head", spine_tx_data, 16'h0401 + 16'(i));
        end
        drive_cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
        chk("t1_empty", spine_tx_valid, 1'b0);
        chk("t1_drops", drop_count, 8'd0);

        // Stalled spine: 10 flits, 8 kept, 2 dropped, then drained in order
        for (int i = 0; i < 10; i++)
            drive_cycle(1'b0, 1'b1, 16'h0501 + 16'(i), 1'b0, 1'b0, 16'h0, 1'b0);
        chk("t2_level", tx_level, 4'd8);
        chk("t2_ovf", tx_overflow, 1'b1);
        chk("t2_drops", drop_count, 8'd2);
        for (int i = 0; i < 8; i++) begin
            chk("t2_drain", spine_tx_data, 16'h0501 + 16'(i));
            drive_cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
        end
        chk("t2_drained", tx_level, 4'd0);

        // Drop counter saturation, then clear coinciding with a drop
        for (int i = 0; i < 308; i++)
            drive_cycle(1'b0, 1'b1, 16'(i), 1'b0, 1'b0, 16'h0, 1'b0);
        chk("t5_sat", drop_count, 8'd255);
        drive_cycle(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("t5_clr_cnt", drop_count, 8'd1);
        chk("t5_clr_ovf", tx_overflow, 1'b1);

        // Reset while in SEND with four flits queued
        drive_cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 4; i++)
            drive_cycle(1'b0, 1'b1, 16'h0601 + 16'(i), 1'b0, i == 3, 16'h7C01, 1'b0);
        chk("t6_pre_liv", leaf_in_valid, 1'b1);
        chk("t6_pre_level", tx_level, 4'd4);
        drive_cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("t6_liv", leaf_in_valid, 1'b0);
        chk("t6_level", tx_level, 4'd0);
        chk("t6_ready", spine_rx_ready, 1'b1);

        // Randomized traffic with varying spine backpressure
        for (int i = 0; i < 3000; i++) begin
            int tr_pct;
            tr_pct = ((i / 200) % 3 == 0) ? 15 : (((i / 200) % 3 == 1) ? 60 : 95);
            drive_cycle($urandom_range(0, 499) == 0,
                        $urandom_range(0, 3) != 0,
                        16'($urandom),
                        $urandom_range(0, 99) < tr_pct,
                        $urandom_range(0, 1) == 1,
                        16'($urandom),
                        $urandom_range(0, 39) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
